// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared Rijndael datapath types, shift offsets and NB legality check
//
// Purpose: common definitions for the ShiftRows stage and the wider round pipeline.
//   byte_t / word_t  : state byte and column word
//   occ_state_t      : occupancy classification of the output buffer
//   nb_legal(nb)     : 1 when nb is a supported block width (4, 6, 8 columns)
//   shift_off(nb, r) : column rotation applied to row r for block width nb
//   byte_lsb(nb, k)  : bit position of state byte k (byte 0 sits in the MSBs)
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  function automatic bit nb_legal(int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael offsets: 256-bit blocks use (1,3,4); 128/192-bit blocks use (1,2,3).
  function automatic int shift_off(int nb, int row);
    if (row == 0) return 0;
    if (nb == 8) return (row == 1) ? 1 : ((row == 2) ? 3 : 4);
    return row;
  endfunction

  function automatic int byte_lsb(int nb, int idx);
    return 8 * (4 * nb - 1 - idx);
  endfunction

endpackage

// File: rtl/shiftrow_pipe_if.sv
// rtl/shiftrow_pipe_if.sv - block stream in/out bundle of the ShiftRows stage
//
// Purpose: groups the upstream and downstream handshakes of shiftrow_pipe.
//   in_valid/in_ready   : upstream handshake
//   in_data             : 32*NB state, byte 0 in the MSBs, column-major
//   in_first / in_inv   : per-block bypass and inverse selectors
//   in_tag              : opaque sideband
//   out_valid/out_ready : downstream handshake
//   out_data / out_tag  : head block of the output buffer
//   modport master      : block producer / consumer side (the environment)
//   modport slave       : the stage itself
interface shiftrow_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);

  logic                in_valid;
  logic                in_ready;
  logic [32*NB-1:0]    in_data;
  logic                in_first;
  logic                in_inv;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [32*NB-1:0]    out_data;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_data, in_first, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_first, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/shiftrow_perm.sv
// rtl/shiftrow_perm.sv - combinational NB-generic ShiftRows / InvShiftRows byte router
//
// Purpose: pure byte permutation of one state block; no storage, no arithmetic.
//   data   in  32*NB  state, byte 0 in the MSBs, byte index = 4*col + row
//   inv    in  1      1 = InvShiftRows, 0 = ShiftRows
//   first  in  1      bypass, wins over inv
//   result out 32*NB  permuted state
module shiftrow_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  input  logic             first,
  output logic [32*NB-1:0] result
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shiftrow_perm: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] fwd;
  logic [32*NB-1:0] bwd;

  // Source columns are resolved at elaboration; wrap is modulo NB, so NB=6
  // must never be reduced with a power-of-two mask.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH      = shift_off(NB, r);
      localparam int FWD_COL = (c + SH) % NB;
      localparam int INV_COL = (c + NB - SH) % NB;

      assign fwd[byte_lsb(NB, 4*c + r) +: 8] = data[byte_lsb(NB, 4*FWD_COL + r) +: 8];
      assign bwd[byte_lsb(NB, 4*c + r) +: 8] = data[byte_lsb(NB, 4*INV_COL + r) +: 8];
    end
  end

  assign result = first ? data : (inv ? bwd : fwd);

endmodule

// File: rtl/shiftrow_pipe.sv
// rtl/shiftrow_pipe.sv - registered ShiftRows stage with a DEPTH-entry output FIFO
//
// Purpose: permutes each accepted block (mode/bypass chosen per block at push)
// and queues {data, tag} in a circular buffer that absorbs downstream stalls.
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset; clears pointers and occupancy
//   bus    slave modport of shiftrow_pipe_if (in_* upstream, out_* downstream)
// Parameters: NB (4/6/8 columns), DEPTH (1..4 entries), TAG_W (tag width).
module shiftrow_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shiftrow_pipe_if.slave bus
);

  localparam int W  = 32 * NB;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((DEPTH < 1) || (DEPTH > 4)) begin : g_bad_depth
    $error("shiftrow_pipe: DEPTH must be 1..4");
  end

  logic [W-1:0]     perm_data;
  logic [W-1:0]     mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];

  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  occ_state_t    occ;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  shiftrow_perm #(.NB(NB)) u_perm (
    .data   (bus.in_data),
    .inv    (bus.in_inv),
    .first  (bus.in_first),
    .result (perm_data)
  );

  // in_ready looks only at registered occupancy: a full buffer refuses a push
  // even in a cycle where the head is being popped.
  assign in_ready  = (count != FULL_CNT) && rst_n;
  assign out_valid = (count != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  // Gated so an empty (or just reset) buffer presents zeros, never stale entries.
  assign bus.out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_tag   = out_valid ? mem_tag[rd_ptr]  : '0;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)           occ = OCC_EMPTY;
    else if (count == FULL_CNT) occ = OCC_FULL;
  end

  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;

    if (push) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    if (pop)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

    unique case (occ)
      OCC_EMPTY: begin
        if (push) count_nxt = count + CW'(1);
      end
      OCC_PARTIAL: begin
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (pop && !push) count_nxt = count - CW'(1);
      end
      OCC_FULL: begin
        if (pop) count_nxt = count - CW'(1);
      end
      default: begin
        count_nxt = count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= perm_data;
      mem_tag[wr_ptr]  <= bus.in_tag;
    end
  end

endmodule

// File: tb/tb_shiftrow_pipe.sv
// tb/tb_shiftrow_pipe.sv - self-checking bench for shiftrow_pipe at NB 4, 6 and 8
module tb_shiftrow_pipe;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  int nbs    [3] = '{4, 6, 8};
  int depths [3] = '{2, 3, 1};

  logic         in_valid_v  [3];
  logic         in_first_v  [3];
  logic         in_inv_v    [3];
  logic         out_ready_v [3];
  logic [255:0] in_data_v   [3];
  logic [3:0]   in_tag_v    [3];

  logic         in_ready_o  [3];
  logic         out_valid_o [3];
  logic [255:0] out_data_o  [3];
  logic [3:0]   out_tag_o   [3];

  logic [259:0] mq [3][$];

  shiftrow_pipe_if #(.NB(4), .TAG_W(4)) i4 ();
  shiftrow_pipe_if #(.NB(6), .TAG_W(4)) i6 ();
  shiftrow_pipe_if #(.NB(8), .TAG_W(4)) i8 ();

  shiftrow_pipe #(.NB(4), .DEPTH(2), .TAG_W(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  shiftrow_pipe #(.NB(6), .DEPTH(3), .TAG_W(4)) d6 (.clk(clk), .rst_n(rst_n), .bus(i6.slave));
  shiftrow_pipe #(.NB(8), .DEPTH(1), .TAG_W(4)) d8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  assign i4.in_valid = in_valid_v[0];  assign i4.in_first = in_first_v[0];
  assign i4.in_inv   = in_inv_v[0];    assign i4.out_ready = out_ready_v[0];
  assign i4.in_data  = in_data_v[0][127:0];
  assign i4.in_tag   = in_tag_v[0];
  assign i6.in_valid = in_valid_v[1];  assign i6.in_first = in_first_v[1];
  assign i6.in_inv   = in_inv_v[1];    assign i6.out_ready = out_ready_v[1];
  assign i6.in_data  = in_data_v[1][191:0];
  assign i6.in_tag   = in_tag_v[1];
  assign i8.in_valid = in_valid_v[2];  assign i8.in_first = in_first_v[2];
  assign i8.in_inv   = in_inv_v[2];    assign i8.out_ready = out_ready_v[2];
  assign i8.in_data  = in_data_v[2];
  assign i8.in_tag   = in_tag_v[2];

  assign in_ready_o[0] = i4.in_ready;  assign out_valid_o[0] = i4.out_valid;
  assign in_ready_o[1] = i6.in_ready;  assign out_valid_o[1] = i6.out_valid;
  assign in_ready_o[2] = i8.in_ready;  assign out_valid_o[2] = i8.out_valid;
  assign out_data_o[0] = 256'(i4.out_data);
  assign out_data_o[1] = 256'(i6.out_data);
  assign out_data_o[2] = 256'(i8.out_data);
  assign out_tag_o[0]  = i4.out_tag;
  assign out_tag_o[1]  = i6.out_tag;
  assign out_tag_o[2]  = i8.out_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference: treat the state as a 4 x nb matrix and rotate each row.
  function automatic logic [255:0] perm_ref(int nb, logic [255:0] din, logic inv, logic first);
    logic [7:0]   st [4][8];
    logic [255:0] res;
    int           sh;
    int           src;
    res = '0;
    for (int col = 0; col < nb; col++)
      for (int row = 0; row < 4; row++)
        st[row][col] = din[8*(4*nb-1-(4*col+row)) +: 8];
    for (int row = 0; row < 4; row++) begin
      if (row == 0)      sh = 0;
      else if (nb == 8)  sh = (row == 1) ? 1 : ((row == 2) ? 3 : 4);
      else               sh = row;
      for (int col = 0; col < nb; col++) begin
        if (first)     src = col;
        else if (inv)  src = (col - sh + nb) % nb;
        else           src = (col + sh) % nb;
        res[8*(4*nb-1-(4*col+row)) +: 8] = st[row][src];
      end
    end
    return res;
  endfunction

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called once per cycle, after inputs are set and before the edge:
  // compares handshake state and the popped head against the model queues.
  task automatic account();
    logic [259:0] head;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("out_valid_nb%0d", nbs[d]), 256'(out_valid_o[d]), 256'(mq[d].size() != 0));
      check($sformatf("in_ready_nb%0d", nbs[d]), 256'(in_ready_o[d]), 256'(mq[d].size() != depths[d]));
      check($sformatf("no_x_nb%0d", nbs[d]),
            256'($isunknown({out_valid_o[d], in_ready_o[d], out_data_o[d], out_tag_o[d]})), 256'(0));
      if (out_valid_o[d] && out_ready_v[d] && mq[d].size() != 0) begin
        head = mq[d].pop_front();
        check($sformatf("head_data_nb%0d", nbs[d]), out_data_o[d], head[255:0]);
        check($sformatf("head_tag_nb%0d", nbs[d]), 256'(out_tag_o[d]), 256'(head[259:256]));
      end
      if (in_valid_v[d] && in_ready_o[d])
        mq[d].push_back({in_tag_v[d], perm_ref(nbs[d], in_data_v[d], in_inv_v[d], in_first_v[d])});
    end
  endtask

  initial begin
    logic [255:0] din;
    logic [3:0]   got [$];
    int           acc;
    logic         pushed;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d] = 1'b0; in_first_v[d] = 1'b0; in_inv_v[d] = 1'b0;
      out_ready_v[d] = 1'b1; in_data_v[d] = '0; in_tag_v[d] = '0;
    end

    // Reset state
    #3;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", 256'(out_valid_o[d]), 256'(0));
      check("rst_in_ready",  256'(in_ready_o[d]),  256'(0));
      check("rst_out_data",  out_data_o[d],        256'(0));
      check("rst_out_tag",   256'(out_tag_o[d]),   256'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check("post_rst_in_ready", 256'(in_ready_o[d]), 256'(1));

    // FIPS-197 Appendix B round 1, forward
    in_valid_v[0] = 1'b1; in_tag_v[0] = 4'h5;
    in_data_v[0] = 256'h0; in_data_v[0][127:0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    account(); tick();
    in_valid_v[0] = 1'b0;
    check("fips_fwd_valid", 256'(out_valid_o[0]), 256'(1));
    check("fips_fwd_data", out_data_o[0], 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    check("fips_fwd_tag", 256'(out_tag_o[0]), 256'(5));
    account(); tick();

    // Inverse
    in_valid_v[0] = 1'b1; in_inv_v[0] = 1'b1; in_tag_v[0] = 4'h6;
    in_data_v[0][127:0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    account(); tick();
    in_valid_v[0] = 1'b0;
    check("fips_inv_data", out_data_o[0], 256'(128'hd42711aee0bf98f1b8b45de51e415230));
    check("fips_inv_tag", 256'(out_tag_o[0]), 256'(6));
    account(); tick();

    // Bypass wins over inverse
    in_valid_v[0] = 1'b1; in_inv_v[0] = 1'b1; in_first_v[0] = 1'b1; in_tag_v[0] = 4'h7;
    account(); tick();
    in_valid_v[0] = 1'b0; in_inv_v[0] = 1'b0; in_first_v[0] = 1'b0;
    check("bypass_data", out_data_o[0], 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    account(); tick();

    // NB=8 offsets (1,3,4)
    for (int k = 0; k < 32; k++) din[8*(31-k) +: 8] = 8'(k);
    in_valid_v[2] = 1'b1; in_data_v[2] = din; in_tag_v[2] = 4'h3;
    account(); tick();
    in_valid_v[2] = 1'b0;
    check("nb8_col0", 256'(out_data_o[2][255:224]), 256'(32'h00050E13));
    check("nb8_col7", 256'(out_data_o[2][31:0]),    256'(32'h1C010A0F));
    account(); tick();

    // Backpressure on DEPTH=2
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1; in_tag_v[0] = 4'd1; in_data_v[0] = {8{$urandom}};
    account(); tick();
    in_tag_v[0] = 4'd2; in_data_v[0] = {8{$urandom}};
    account(); tick();
    check("bp_full_in_ready", 256'(in_ready_o[0]), 256'(0));
    in_tag_v[0] = 4'd3; in_data_v[0] = {8{$urandom}};
    account(); tick();
    check("bp_held_in_ready", 256'(in_ready_o[0]), 256'(0));
    check("bp_head_tag", 256'(out_tag_o[0]), 256'(1));
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      if (out_valid_o[0]) got.push_back(out_tag_o[0]);
      pushed = in_valid_v[0] && in_ready_o[0];
      account(); tick();
      if (pushed) in_valid_v[0] = 1'b0;
    end
    check("bp_out_count", 256'(got.size()), 256'(3));
    for (int i = 0; i < got.size(); i++) check("bp_order", 256'(got[i]), 256'(i + 1));
    in_valid_v[0] = 1'b0;
    repeat (3) begin account(); tick(); end

    // Continuous flow: one block per cycle
    acc = 0;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_tag_v[0] = 4'(i); in_data_v[0] = {8{$urandom}};
      if (in_ready_o[0]) acc++;
      account(); tick();
    end
    in_valid_v[0] = 1'b0;
    check("flow_accepts", 256'(acc), 256'(8));
    repeat (3) begin account(); tick(); end

    // Reset mid-operation with two blocks buffered
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    in_tag_v[0] = 4'd9;  account(); tick();
    in_tag_v[0] = 4'd10; account(); tick();
    in_valid_v[0] = 1'b0;
    check("mid_full_valid", 256'(out_valid_o[0]), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 256'(out_valid_o[0]), 256'(0));
    check("mid_rst_in_ready",  256'(in_ready_o[0]),  256'(0));
    check("mid_rst_out_data",  out_data_o[0],        256'(0));
    #2 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) mq[d].delete();
    tick();
    for (int d = 0; d < 3; d++) check("mid_rel_in_ready", 256'(in_ready_o[d]), 256'(1));
    out_ready_v[0] = 1'b1;
    repeat (4) begin account(); tick(); end

    // Randomized handshakes, modes and data on all three widths
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid_v[d]  = ($urandom_range(0, 3) != 0);
        out_ready_v[d] = ($urandom_range(0, 2) != 0);
        in_first_v[d]  = ($urandom_range(0, 3) == 0);
        in_inv_v[d]    = 1'($urandom_range(0, 1));
        in_tag_v[d]    = 4'($urandom);
        for (int w = 0; w < 8; w++) in_data_v[d][32*w +: 32] = $urandom;
      end
      account(); tick();
    end
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b1;
    end
    repeat (6) begin account(); tick(); end
    for (int d = 0; d < 3; d++) check("drain_empty", 256'(mq[d].size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
